// File: rtl/pwm_pkg.sv
// ============================================================================
// Module : pwm_pkg
// Shared widths, constants and the duty compare rule for the PWM output block.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam int PWM_CNT_W = 8;
  localparam int NUM_CH    = 16;

  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;
  typedef logic [NUM_CH-1:0]    ch_vec_t;

  localparam pwm_cnt_t DUTY_FULL = 8'hFF;

  // Full-scale duty is forced high so 0xFF really means 100%, not 255/256.
  function automatic logic pwm_compare(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_prescaler.sv
// ============================================================================
// Module : pwm_prescaler
// Divides clk by CLK_DIV and emits a one-cycle tick on the last count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pwm_prescaler #(
  parameter int CLK_DIV = 3000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pwm_output_ctrl.sv
// ============================================================================
// Module : pwm_output_ctrl
// 16 registered outputs, each static-low, static-high or shared-PWM driven.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pwm_output_ctrl
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 3000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        en_reg_out_7_0,
  input  logic [7:0]        en_reg_out_15_8,
  input  logic [7:0]        en_reg_pwm_7_0,
  input  logic [7:0]        en_reg_pwm_15_8,
  input  logic [7:0]        pwm_duty_cycle,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  logic     tick;
  logic     wrap;
  logic     pwm_sig;
  ch_vec_t  en_out;
  ch_vec_t  en_pwm;

  pwm_cnt_t pwm_cnt_q;
  pwm_cnt_t pwm_cnt_d;
  pwm_cnt_t duty_shadow_q;
  pwm_cnt_t duty_shadow_d;
  logic     period_start_q;
  logic     period_start_d;
  ch_vec_t  out_q;
  ch_vec_t  out_d;

  pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // The shadow only reloads at the wrap, so a period never sees a mid-way duty change.
  always_comb begin
    wrap           = tick && (pwm_cnt_q == DUTY_FULL);
    pwm_cnt_d      = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    duty_shadow_d  = wrap ? pwm_duty_cycle : duty_shadow_q;
    period_start_d = wrap;
    pwm_sig        = pwm_compare(pwm_cnt_q, duty_shadow_q);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign out_d[i] = en_out[i] & (en_pwm[i] ? pwm_sig : 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q      <= '0;
      duty_shadow_q  <= '0;
      period_start_q <= 1'b0;
      out_q          <= '0;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      duty_shadow_q  <= duty_shadow_d;
      period_start_q <= period_start_d;
      out_q          <= out_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

`default_nettype wire
